// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding, operation codes and the full-adder carry helper.
package addsub_pkg;

    // FSM state encoding (2-bit, kept as plain constants)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Operation select values carried on the op input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Majority of three inputs: the carry-out of a 1-bit full adder
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single 1-bit full adder; purely combinational.
module full_adder_cell
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of one bit position
    always_comb begin
        s    = a ^ b ^ cin;
        cout = maj3(a, b, cin);
    end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a
// single full_adder_cell. Subtraction is a + ~b + 1 (carry preset to 1).
// Optional feature macro: ADDSUB_OVF_EN -- when defined, the carry into the
// MSB is kept in a register and ovf reports signed overflow; when undefined,
// ovf is tied low and that register does not exist.
module serial_addsub_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             cout_reg;

    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_cout;

    // A new operation is only taken when the datapath is not busy
    assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_CNT);

    full_adder_cell u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Next-state logic: start in RUN is ignored, DONE lasts one cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand load on accept, then one serial bit per RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            cout_reg   <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= (op == OP_SUB) ? ~b : b;
            carry_reg <= op;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            result_reg <= {fa_s, result_reg[WIDTH-1:1]};
            a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
            b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
            carry_reg  <= fa_cout;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (last_bit) begin
                cout_reg <= fa_cout;
            end
        end
    end

`ifdef ADDSUB_OVF_EN
    logic msb_cin_reg;

    // Capture the carry entering the MSB so overflow can be held after RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_cin_reg <= 1'b0;
        end else if (last_bit) begin
            msb_cin_reg <= carry_reg;
        end
    end

    assign ovf = msb_cin_reg ^ cout_reg;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_reg == RUN);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign cout   = cout_reg;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl (WIDTH=4): directed corner
// cases plus randomized operations compared against an arithmetic model.
module tb_serial_addsub_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    function automatic int to_signed(input logic [W-1:0] x);
        return x[W-1] ? int'(x) - (1 << W) : int'(x);
    endfunction

    task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic v);
        int ux, uy, sres;
        ux = int'(x);
        uy = int'(y);
        if (o == 1'b0) begin
            r    = W'(ux + uy);
            c    = (ux + uy) >= (1 << W);
            sres = to_signed(x) + to_signed(y);
        end else begin
            r    = W'(ux - uy + (1 << W));
            c    = (ux >= uy);
            sres = to_signed(x) - to_signed(y);
        end
`ifdef ADDSUB_OVF_EN
        v = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
`else
        v = 1'b0;
`endif
    endtask

    // Present an operation at a negedge; returns at the negedge after the accepting edge
    task automatic start_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic check_done(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic         ec, ev;
        model(o, x, y, er, ec, ev);
        $display("op=%0d a=%0d b=%0d -> result=%0d cout=%0d ovf=%0d (model %0d %0d %0d)",
                 o, x, y, result, cout, ovf, er, ec, ev);
        check({tag, "_done"},   32'(done),   32'd1);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"},   32'(cout),   32'(ec));
        check({tag, "_ovf"},    32'(ovf),    32'(ev));
    endtask

    // Wait W cycles after start_op; done must appear only on the last
    task automatic finish_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (i < W) check({tag, "_early_done"}, 32'(done), 32'd0);
        end
        check_done(tag, o, x, y);
    endtask

    task automatic run_op(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        start_op(o, x, y);
        finish_op(tag, o, x, y);
    endtask

    initial begin
        logic [W-1:0] held;
        logic         ro;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout",   32'(cout),   32'd0);
        check("rst_ovf",    32'(ovf),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op("add_5_3", 1'b0, 4'd5, 4'd3);
        @(negedge clk);
        check("idle_after_done", 32'(done), 32'd0);
        check("idle_hold_result", 32'(result), 32'd8);
        run_op("sub_3_5", 1'b1, 4'd3, 4'd5);
        @(negedge clk);
        run_op("sub_7_7", 1'b1, 4'd7, 4'd7);
        @(negedge clk);
        run_op("add_15_1", 1'b0, 4'd15, 4'd1);
        @(negedge clk);

        // Start pulse during RUN must be ignored
        start_op(1'b0, 4'd5, 4'd3);
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b1;
                op    = 1'b0;
                a     = 4'd1;
                b     = 4'd1;
            end else if (i == 2) begin
                start = 1'b0;
            end
            if (i < W) check("ign_early_done", 32'(done), 32'd0);
        end
        check_done("ignore", 1'b0, 4'd5, 4'd3);
        @(negedge clk);
        check("ign_single_done", 32'(done), 32'd0);
        check("ign_no_restart",  32'(busy), 32'd0);

        // Back-to-back: start held through DONE
        start_op(1'b0, 4'd5, 4'd3);
        finish_op("b2b_first", 1'b0, 4'd5, 4'd3);
        start = 1'b1;
        op    = 1'b1;
        a     = 4'd3;
        b     = 4'd5;
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_one_cycle", 32'(done), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        finish_op("b2b_second", 1'b1, 4'd3, 4'd5);
        @(negedge clk);

        // Reset in the middle of RUN
        start_op(1'b1, 4'd7, 4'd7);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_cout",   32'(cout),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        run_op("after_rst", 1'b0, 4'd15, 4'd1);

        // Randomized operations, some back-to-back, some with idle gaps
        for (int n = 0; n < 60; n++) begin
            ro = 1'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            run_op("rand", ro, ra, rb);
            if ($urandom_range(0, 1) == 1) begin
                held = result;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    @(negedge clk);
                    check("rand_hold", 32'(result), 32'(held));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width; legal range 2..16.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; one clock, asynchronous assert, active-low (decided).
REQ-004 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 op  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse; high while state is DONE.
REQ-010 result  output  WIDTH  sum/difference; valid from done until the next accepted start.
REQ-011 cout  output  1  final carry; for subtract, 1 = no borrow (a >= b unsigned).
REQ-012 ovf  output  1  signed two's-complement overflow flag.

Function
REQ-013 The block SHALL compute a +/- b bit-serially, LSB first, one bit per clock, through a single 1-bit full-adder cell.
REQ-014 States SHALL be IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH RUN edges, DONE->RUN on start else DONE->IDLE.
REQ-015 On the accepting edge: A shift register <= a, B shift register <= (op ? ~b : b), carry <= op, bit counter <= 0.
REQ-016 Each RUN edge: sum bit = A[0]^B[0]^carry shifted into result MSB side (result shifts right), A/B shift right, carry <= majority(A[0],B[0],carry), counter increments.
REQ-017 Carry into the MSB SHALL be retained; ovf = carry-into-MSB XOR carry-out on the last RUN edge.
REQ-018 Latency: start sampled at edge 0 -> done high for exactly the cycle after edge WIDTH; busy high for cycles after edges 0..WIDTH-1.
REQ-019 start while RUN SHALL be ignored; no queueing; operands/op changes during RUN SHALL have no effect.
REQ-020 start while DONE SHALL be accepted (back-to-back); done still pulses exactly one cycle.
REQ-021 result, cout, ovf SHALL hold their value in DONE and IDLE until the next accepted start; during RUN result is undefined-for-use (partial).
REQ-022 All arithmetic modulo 2^WIDTH; counter width = clog2(WIDTH).

Reset
REQ-023 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, cout=0, ovf=0, counter=0, carry=0, shift registers=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after release behaves as from power-up.

Configuration
REQ-025 Macro ADDSUB_OVF_EN: defined -> ovf computed per REQ-017 and carry-into-MSB register present.
REQ-026 ADDSUB_OVF_EN undefined -> ovf port present but tied 0, carry-into-MSB register removed; all other behaviour identical.

Structure
REQ-027 Shared package addsub_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and op constants OP_ADD=1'b0, OP_SUB=1'b1.
REQ-028 One sub-module full_adder_cell (a, b, cin -> s, cout, purely combinational) SHALL be instantiated once; control, counter and shift registers live in serial_addsub_ctrl.

Verification (WIDTH=4)
REQ-029 op=0, a=5, b=3, start 1 cycle -> done 4 cycles later, result=8, cout=0, ovf=1 (ovf=0 without macro).
REQ-030 op=1, a=3, b=5 -> result=14, cout=0, ovf=0; op=1, a=7, b=7 -> result=0, cout=1, ovf=0.
REQ-031 op=0, a=15, b=1 -> result=0, cout=1, ovf=0.
REQ-032 start pulsed again 2 cycles into RUN with a=1, b=1 -> ignored; first operation's result delivered, single done pulse.
REQ-033 start held high through DONE with new operands -> second operation starts, second done exactly WIDTH+1 cycles after first done.
REQ-034 rst_n low 2 cycles into RUN -> outputs zero immediately, no done pulse; next start completes correctly.
